// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: datapath widths and the ALU operation encoding.
// Used by operand_fetch and the ALU.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: decode issue handshake, ALU output handshake and writeback port.
// master = decode/ALU/writeback side, slave = operand_fetch.
interface operand_fetch_if;
    import alu_pkg::*;

    // decode -> operand fetch
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] imm;
    logic                  ALUsrc;
    alu_ctrl_t             ctrl_in;

    // operand fetch -> ALU
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUop1;
    logic [DATA_WIDTH-1:0] ALUop2;
    alu_ctrl_t             ALUControl;
    logic [ADDR_WIDTH-1:0] out_rd;

    // writeback
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    modport master (
        output in_valid, rs1, rs2, rd, imm, ALUsrc, ctrl_in,
        output out_ready,
        output wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, ALUop1, ALUop2, ALUControl, out_rd
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, imm, ALUsrc, ctrl_in,
        input  out_ready,
        input  wb_en, wb_addr, wb_data,
        output in_ready, out_valid, ALUop1, ALUop2, ALUControl, out_rd
    );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port.
// x0 reads as zero and ignores writes.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage: clear on reset, otherwise write any register except x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file read, op2 select, pending-writeback
// scoreboard and a single registered output slot feeding the ALU.
// Optional macro WB_BYPASS_EN: forward same-cycle writeback data into the
// captured operands and clear that source's hazard in the same cycle.
module operand_fetch #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = alu_pkg::ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    import alu_pkg::*;

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_next;
    logic [NREGS-1:0]      pending_eff;
    logic [DATA_WIDTH-1:0] rf_data1;
    logic [DATA_WIDTH-1:0] rf_data2;
    logic [DATA_WIDTH-1:0] src1_val;
    logic [DATA_WIDTH-1:0] src2_val;
    logic                  wb_hit;
    logic                  hazard;
    logic                  accept;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    alu_ctrl_t             ctrl_q;
    logic [ADDR_WIDTH-1:0] rd_q;

    assign wb_hit = bus.wb_en && (bus.wb_addr != '0);

    reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (bus.rs1),
        .rd_addr2 (bus.rs2),
        .rd_data1 (rf_data1),
        .rd_data2 (rf_data2),
        .wr_en    (wb_hit),
        .wr_addr  (bus.wb_addr),
        .wr_data  (bus.wb_data)
    );

`ifdef WB_BYPASS_EN
    // Hazard view with this cycle's writeback already retired.
    always_comb begin
        pending_eff = pending;
        if (wb_hit) begin
            pending_eff[bus.wb_addr] = 1'b0;
        end
    end

    assign src1_val = (wb_hit && (bus.wb_addr == bus.rs1)) ? bus.wb_data : rf_data1;
    assign src2_val = (wb_hit && (bus.wb_addr == bus.rs2)) ? bus.wb_data : rf_data2;
`else
    assign pending_eff = pending;
    assign src1_val    = rf_data1;
    assign src2_val    = rf_data2;
`endif

    assign hazard       = pending_eff[bus.rs1] | (pending_eff[bus.rs2] & ~bus.ALUsrc);
    assign bus.in_ready = ~hazard & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Scoreboard update: writeback clears, then accept sets, so a same-edge
    // set and clear of one index leaves it pending. x0 is never pending.
    always_comb begin
        pending_next = pending;
        if (wb_hit) begin
            pending_next[bus.wb_addr] = 1'b0;
        end
        if (accept && (bus.rd != '0)) begin
            pending_next[bus.rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Output slot: load on accept, empty when drained, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            ctrl_q      <= ALU_ADD;
            rd_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            op1_q       <= src1_val;
            op2_q       <= bus.ALUsrc ? bus.imm : src2_val;
            ctrl_q      <= bus.ctrl_in;
            rd_q        <= bus.rd;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.ALUop1     = op1_q;
    assign bus.ALUop2     = op2_q;
    assign bus.ALUControl = ctrl_q;
    assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic,
// all checked against a register/pending-set model of the stage.
// Honours WB_BYPASS_EN the same way as the design.
module tb_operand_fetch;
    import alu_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        in_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        src;
        logic [2:0]  ctrl;
        logic        out_ready;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_fetch_if bus_if ();

    operand_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen_ready;

    // Reference state: architectural registers, set of pending indices, output slot.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ov;
    logic [31:0] m_op1, m_op2;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.out_ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t issue(input int rs1, input int rs2, input int rd,
                                    input logic src, input logic [31:0] imm, input int ctrl);
        stim_t s;
        s = idle();
        s.in_valid = 1'b1;
        s.rs1  = 5'(rs1);
        s.rs2  = 5'(rs2);
        s.rd   = 5'(rd);
        s.src  = src;
        s.imm  = imm;
        s.ctrl = 3'(ctrl);
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input stim_t s);
        if (a == 0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (s.wb_en && s.wb_addr == a) return s.wb_data;
`endif
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_ov = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_ctrl = 3'd0; m_rd = 5'd0;
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check outputs after posedge.
    task automatic step(input stim_t s);
        bit pend_eff [32];
        bit busy, rdy, acc;
        @(negedge clk);
        rst               = s.rst;
        bus_if.in_valid   = s.in_valid;
        bus_if.rs1        = s.rs1;
        bus_if.rs2        = s.rs2;
        bus_if.rd         = s.rd;
        bus_if.imm        = s.imm;
        bus_if.ALUsrc     = s.src;
        bus_if.ctrl_in    = alu_ctrl_t'(s.ctrl);
        bus_if.out_ready  = s.out_ready;
        bus_if.wb_en      = s.wb_en;
        bus_if.wb_addr    = s.wb_addr;
        bus_if.wb_data    = s.wb_data;
        #1;
        seen_ready = bus_if.in_ready;
        if (s.rst) begin
            model_reset();
        end else begin
            pend_eff = m_pend;
`ifdef WB_BYPASS_EN
            if (s.wb_en && s.wb_addr != 0) pend_eff[s.wb_addr] = 1'b0;
`endif
            busy = pend_eff[s.rs1] || (pend_eff[s.rs2] && !s.src);
            rdy  = !busy && (!m_ov || s.out_ready);
            check("in_ready", 32'(bus_if.in_ready), 32'(rdy));
            acc = s.in_valid && rdy;
            if (acc) begin
                m_op1  = model_read(s.rs1, s);
                m_op2  = s.src ? s.imm : model_read(s.rs2, s);
                m_ctrl = s.ctrl;
                m_rd   = s.rd;
                m_ov   = 1'b1;
            end else if (s.out_ready) begin
                m_ov = 1'b0;
            end
            if (s.wb_en && s.wb_addr != 0) begin
                m_regs[s.wb_addr] = s.wb_data;
                m_pend[s.wb_addr] = 1'b0;
            end
            if (acc && s.rd != 0) m_pend[s.rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid",  32'(bus_if.out_valid),  32'(m_ov));
        check("ALUop1",     bus_if.ALUop1,          m_op1);
        check("ALUop2",     bus_if.ALUop2,          m_op2);
        check("ALUControl", 32'(bus_if.ALUControl), 32'(m_ctrl));
        check("out_rd",     32'(bus_if.out_rd),     32'(m_rd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        model_reset();

        // 1: reset for two cycles, then read every register.
        s = idle(); s.rst = 1'b1;
        step(s);
        step(s);
        check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
        for (int i = 1; i < 32; i++) begin
            step(issue(i, i, 0, 1'b0, 32'd0, 0));
            if (i == 1) check("reset_in_ready", 32'(seen_ready), 32'd1);
        end
        check("reset_read_x31", bus_if.ALUop1, 32'd0);

        // 2: write x5 = 7, then x5 + imm 3.
        s = idle(); s.wb_en = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'd7;
        step(s);
        step(issue(5, 0, 0, 1'b1, 32'd3, 0));
        check("add_op1", bus_if.ALUop1, 32'd7);
        check("add_op2", bus_if.ALUop2, 32'd3);
        check("add_sum", bus_if.ALUop1 + bus_if.ALUop2, 32'd10);

        // 3: RAW hazard on x6, released by writeback of 9.
        step(issue(0, 0, 6, 1'b1, 32'd1, 1));
        step(issue(6, 0, 0, 1'b1, 32'd0, 0));
        check("raw_stall", 32'(seen_ready), 32'd0);
        s = issue(6, 0, 0, 1'b1, 32'd0, 0);
        s.wb_en = 1'b1; s.wb_addr = 5'd6; s.wb_data = 32'd9;
        step(s);
`ifdef WB_BYPASS_EN
        check("raw_wb_cycle_ready", 32'(seen_ready), 32'd1);
`else
        check("raw_wb_cycle_ready", 32'(seen_ready), 32'd0);
        step(issue(6, 0, 0, 1'b1, 32'd0, 0));
        check("raw_after_wb_ready", 32'(seen_ready), 32'd1);
`endif
        check("raw_op1", bus_if.ALUop1, 32'd9);

        // 4: ALU back-pressure for three cycles, then drain.
        step(issue(5, 0, 0, 1'b1, 32'd3, 2));
        for (int i = 0; i < 3; i++) begin
            s = issue(0, 0, 0, 1'b1, 32'd0, 0); s.out_ready = 1'b0;
            step(s);
            check("bp_in_ready", 32'(seen_ready), 32'd0);
            check("bp_hold_op1", bus_if.ALUop1, 32'd7);
        end
        step(idle());
        check("bp_drain", 32'(bus_if.out_valid), 32'd0);

        // 5: x0 is immutable and never pending.
        s = issue(0, 0, 0, 1'b0, 32'd0, 0);
        s.wb_en = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'hFFFF_FFFF;
        step(s);
        check("x0_op1", bus_if.ALUop1, 32'd0);
        step(issue(0, 0, 0, 1'b0, 32'd0, 0));
        check("x0_no_stall", 32'(seen_ready), 32'd1);

        // 6: reset while stalled on x6.
        step(issue(0, 0, 6, 1'b1, 32'd5, 3));
        step(issue(6, 0, 0, 1'b1, 32'd0, 0));
        check("rst_pre_stall", 32'(seen_ready), 32'd0);
        s = issue(6, 0, 0, 1'b1, 32'd0, 0); s.rst = 1'b1;
        step(s);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        step(issue(6, 0, 0, 1'b1, 32'd0, 0));
        check("rst_post_ready", 32'(seen_ready), 32'd1);
        check("rst_post_op1", bus_if.ALUop1, 32'd0);

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            s.rst       = ($urandom_range(0, 199) == 0);
            s.in_valid  = ($urandom_range(0, 3) != 0);
            s.rs1       = 5'($urandom_range(0, 7));
            s.rs2       = 5'($urandom_range(0, 7));
            s.rd        = 5'($urandom_range(0, 7));
            s.imm       = $urandom;
            s.src       = 1'($urandom_range(0, 1));
            s.ctrl      = 3'($urandom_range(0, 7));
            s.out_ready = ($urandom_range(0, 9) < 7);
            s.wb_en     = ($urandom_range(0, 9) < 4);
            s.wb_addr   = 5'($urandom_range(0, 7));
            s.wb_data   = $urandom;
            step(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
